rgb2hsv_seq: RTL



---
 rtl/rgb2hsv_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rgb2hsv_seq.sv
// Sequential RGB-to-HSV converter: one shared 16-step restoring divider computes
// S = 255*delta/max, then the hue offset 43*|num|/delta. Fixed 34-cycle latency.
module rgb2hsv_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] tRGB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] tHSV
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, where tHSV is held stable.
   typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;

   state_t      state_q, state_d;
   logic [23:0] pix_q, pix_d;
   logic [7:0]  max_q, max_d;
   logic [7:0]  delta_q, delta_d;
   logic [7:0]  abs_q, abs_d;
   logic        neg_q, neg_d;
   logic [7:0]  base_q, base_d;
   logic [7:0]  s_q, s_d;
   logic [8:0]  rem_q, rem_d;
   logic [15:0] quo_q, quo_d;
   logic [15:0] dvd_q, dvd_d;
   logic [7:0]  dsr_q, dsr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] hsv_q, hsv_d;

   logic [7:0]  r_v, g_v, b_v, max_v, min_v, abs_v, base_v, off_v, h_v;
   logic [8:0]  num_v, num_neg_v, rem_sh, rem_step;
   logic [15:0] quo_step;
   logic        qbit;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      max_d   = max_q;
      delta_d = delta_q;
      abs_d   = abs_q;
      neg_d   = neg_q;
      base_d  = base_q;
      s_d     = s_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      hsv_d   = hsv_q;

      // One restoring step, used by both division phases.
      rem_sh = {rem_q[7:0], dvd_q[15]};
      if (rem_sh >= {1'b0, dsr_q}) begin
         rem_step = rem_sh - {1'b0, dsr_q};
         qbit     = 1'b1;
      end else begin
         rem_step = rem_sh;
         qbit     = 1'b0;
      end
      quo_step = {quo_q[14:0], qbit};

      r_v = pix_q[23:16];
      g_v = pix_q[15:8];
      b_v = pix_q[7:0];
      // Max-channel ties resolve R, then G, then B.
      if (r_v >= g_v && r_v >= b_v) begin
         max_v  = r_v;
         num_v  = {1'b0, g_v} - {1'b0, b_v};
         base_v = 8'd0;
      end else if (g_v >= b_v) begin
         max_v  = g_v;
         num_v  = {1'b0, b_v} - {1'b0, r_v};
         base_v = 8'd85;
      end else begin
         max_v  = b_v;
         num_v  = {1'b0, r_v} - {1'b0, g_v};
         base_v = 8'd171;
      end
      min_v = r_v;
      if (g_v < min_v) min_v = g_v;
      if (b_v < min_v) min_v = b_v;
      num_neg_v = 9'd0 - num_v;
      abs_v     = num_v[8] ? num_neg_v[7:0] : num_v[7:0];

      off_v = quo_q[7:0];
      h_v   = neg_q ? (base_q - off_v) : (base_q + off_v);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pix_d   = tRGB;
               state_d = PREP;
            end
         end
         PREP: begin
            max_d   = max_v;
            delta_d = max_v - min_v;
            abs_d   = abs_v;
            neg_d   = num_v[8];
            base_d  = base_v;
            dvd_d   = {max_v - min_v, 8'd0} - {8'd0, max_v - min_v};
            dsr_d   = max_v;
            rem_d   = 9'd0;
            quo_d   = 16'd0;
            cnt_d   = 5'd0;
            state_d = DIV_S;
         end
         DIV_S: begin
            rem_d = rem_step;
            quo_d = quo_step;
            dvd_d = {dvd_q[14:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               s_d     = (max_q == 8'd0) ? 8'd0 : quo_step[7:0];
               dvd_d   = {8'd0, abs_q} * 16'd43;
               dsr_d   = delta_q;
               rem_d   = 9'd0;
               quo_d   = 16'd0;
               cnt_d   = 5'd0;
               state_d = DIV_H;
            end
         end
         DIV_H: begin
            if (cnt_q == 5'd16) begin
               // Grey pixels: the divider ran on delta=0, so discard its result.
               if (delta_q == 8'd0) hsv_d = {8'd0, 8'd0, max_q};
               else                 hsv_d = {h_v, s_q, max_q};
               state_d = DONE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               dvd_d = {dvd_q[14:0], 1'b0};
               cnt_d = cnt_q + 5'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pix_q   <= '0;
         max_q   <= '0;
         delta_q <= '0;
         abs_q   <= '0;
         neg_q   <= 1'b0;
         base_q  <= '0;
         s_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         hsv_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         max_q   <= max_d;
         delta_q <= delta_d;
         abs_q   <= abs_d;
         neg_q   <= neg_d;
         base_q  <= base_d;
         s_q     <= s_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         hsv_q   <= hsv_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign tHSV      = hsv_q;

endmodule
